// File: rtl/sdram_write_queue.sv
// rtl/sdram_write_queue.sv - host write FIFO and one-at-a-time sequencer for the SDRAM write stage
// Optional WAIT-state watchdog enabled by defining SDRAM_WQ_TIMEOUT_EN.
module sdram_write_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                    iclk,
    input  logic                    ireset_n,
    input  logic                    iwr_valid,
    output logic                    owr_ready,
    input  logic [24:0]             iwr_addr,
    input  logic [15:0]             iwr_data,
    input  logic                    igrant,
    output logic                    oreq,
    output logic                    oenb,
    input  logic                    ifin,
    output logic [12:0]             orow,
    output logic [1:0]              obank,
    output logic [9:0]              ocolumn,
    output logic [15:0]             odata,
    output logic [$clog2(DEPTH):0]  olevel,
    output logic                    oerr
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [24:0]   addr_mem [DEPTH];
    logic [15:0]   data_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [1:0]    state;
    logic          push;
    logic          pop;
    logic          start;
    logic          wd_expire;
    logic [24:0]   head_addr;

    assign owr_ready = (level != FULL_LEVEL);
    assign push      = iwr_valid & owr_ready;
    assign start     = (state == ST_IDLE) && (level != '0) && igrant;
    assign pop       = ((state == ST_WAIT) && ifin) || wd_expire;
    assign head_addr = addr_mem[rd_ptr];

    assign oreq   = (state == ST_ISSUE);
    assign oenb   = (state != ST_IDLE);
    assign olevel = level;

    // Storage needs no reset: level gates every read of it.
    always_ff @(posedge iclk) begin
        if (push) begin
            addr_mem[wr_ptr] <= iwr_addr;
            data_mem[wr_ptr] <= iwr_data;
        end
    end

`ifdef SDRAM_WQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wd_cnt;

    assign wd_expire = (state == ST_WAIT) && !ifin && (wd_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            wd_cnt <= '0;
            oerr   <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_expire) begin
                oerr <= 1'b1;
            end
        end
    end
`else
    // TIMEOUT only matters with the watchdog; this term is constant false.
    assign wd_expire = (TIMEOUT < 0);
    assign oerr      = 1'b0;
`endif

    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            state   <= ST_IDLE;
            orow    <= '0;
            obank   <= '0;
            ocolumn <= '0;
            odata   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            // Fields latch only on IDLE->ISSUE so they stay put while oenb is high.
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_ISSUE;
                        orow    <= head_addr[24:12];
                        obank   <= head_addr[11:10];
                        ocolumn <= head_addr[9:0];
                        odata   <= data_mem[rd_ptr];
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (wd_expire) begin
                        state <= ST_IDLE;
                    end else if (ifin) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (!ifin) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
